dm_port_ctrl: RTL

DM_PORT_CTRL -- requirements
Module: dm_port_ctrl

---
 rtl/dm_port_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dm_port_ctrl.sv
// dm_port_ctrl: data-memory port controller with a posted store buffer.
//
// The CPU side issues level loads (MemRead_IN) and one-cycle store pulses
// (MemWrite_IN). Stores go into a FIFO store buffer. The buffer drains ahead
// of loads, so a load always sees every store issued before it. Every SRAM
// transaction waits LAT cycles first. Partial stores use a read-modify-write
// sequence. Byte lanes are big-endian: offset 0 is bits [31:24].
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   MemRead_IN          level load request, held until DataValid_OUT
//   MemWrite_IN         one-cycle store pulse
//   MemFlush_IN         one-cycle flush request
//   Address_IN          byte address; bits [ADDR_W+1:2] select the SRAM word
//   WriteData_IN        store data; the low n bytes are used
//   WriteSize_IN        0=word, 1=byte, 2=half, 3=three bytes
//   ReadData_OUT        last loaded word; holds until the next load completes
//   DataValid_OUT       one-cycle load-complete pulse
//   Busy_OUT            store buffer full
//   FlushDone_OUT       one-cycle pulse when a requested flush has drained
//   Overflow_OUT        sticky: a store was dropped because the buffer was full
//   sram_en/we/addr/wdata, sram_rdata
//                       single-port SRAM; read data arrives the cycle after en
module dm_port_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int LAT      = 2,
    parameter int WB_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MemRead_IN,
    input  logic              MemWrite_IN,
    input  logic              MemFlush_IN,
    input  logic [31:0]       Address_IN,
    input  logic [31:0]       WriteData_IN,
    input  logic [1:0]        WriteSize_IN,
    output logic [31:0]       ReadData_OUT,
    output logic              DataValid_OUT,
    output logic              Busy_OUT,
    output logic              FlushDone_OUT,
    output logic              Overflow_OUT,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CW = $clog2(WB_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W+1:0] addr;
        logic [31:0]       data;
        logic [1:0]        size;
    } sb_entry_t;

    typedef enum logic [2:0] {
        IDLE, WAIT, RD, RDCAP, RMW_RD, RMW_MRG, WR, RESP
    } state_t;

    state_t state, state_d;

    // Only the word-address bits and the byte offset are used.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Address_IN[31:ADDR_W+2];

    // ------------------------------------------------------------------
    // Store buffer
    // ------------------------------------------------------------------
    sb_entry_t         sb_mem [WB_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, empty, enq, deq;
    sb_entry_t         head;

    assign full  = (count == CW'(WB_DEPTH));
    assign empty = (count == '0);
    assign enq   = MemWrite_IN && !full;
    assign deq   = (state == WR);
    assign head  = sb_mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A store needs the old word unless it covers all four bytes.
    function automatic logic needs_rmw(input logic [1:0] size, input logic [1:0] off);
        return (size != 2'd0) || (off != 2'd0);
    endfunction

    always_ff @(posedge CLK) begin
        if (enq)
            sb_mem[wr_ptr] <= '{addr: Address_IN[ADDR_W+1:0],
                                data: WriteData_IN,
                                size: WriteSize_IN};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transaction registers
    // ------------------------------------------------------------------
    logic [ADDR_W+1:0] op_addr;
    logic [31:0]       op_data;
    logic [1:0]        op_size;
    logic              op_load;
    logic [31:0]       wr_word;
    logic [3:0]        wait_cnt;
    logic              wait_done;
    logic              take_store, take_load;
    logic              flush_pend, flush_fire;
    logic [31:0]       merged;
    int                mrg_n, mrg_off;

    assign wait_done = (wait_cnt == 4'(LAT - 1));

    // Lay the low mrg_n bytes of op_data, MSB first, over the old word
    // starting at the byte offset. Bytes that would land past offset 3 are
    // discarded.
    always_comb begin
        merged  = sram_rdata;
        mrg_n   = (op_size == 2'd0) ? 4 : int'(op_size);
        mrg_off = int'(op_addr[1:0]);
        for (int o = 0; o < 4; o++) begin
            if (o >= mrg_off && o < mrg_off + mrg_n)
                merged[8*(3-o) +: 8] = op_data[8*(mrg_n-1-(o-mrg_off)) +: 8];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d       = state;
        take_store    = 1'b0;
        take_load     = 1'b0;
        sram_en       = 1'b0;
        sram_we       = 1'b0;
        DataValid_OUT = 1'b0;
        flush_fire    = flush_pend && (state == IDLE) && empty;
        case (state)
            IDLE: begin
                if (!empty) begin
                    take_store = 1'b1;
                    if (LAT == 0)
                        state_d = needs_rmw(head.size, head.addr[1:0]) ? RMW_RD : WR;
                    else
                        state_d = WAIT;
                end else if (MemRead_IN && !MemWrite_IN) begin
                    // A store arriving this cycle must reach SRAM first.
                    take_load = 1'b1;
                    state_d   = (LAT == 0) ? RD : WAIT;
                end
            end
            WAIT: begin
                if (wait_done) begin
                    if (op_load)
                        // A store posted while the load waited would be
                        // bypassed; give up and let IDLE drain it first. The
                        // held MemRead_IN reissues the load.
                        state_d = (empty && !MemWrite_IN) ? RD : IDLE;
                    else
                        state_d = needs_rmw(op_size, op_addr[1:0]) ? RMW_RD : WR;
                end
            end
            RD: begin
                sram_en = 1'b1;
                state_d = RDCAP;
            end
            RDCAP:   state_d = RESP;
            RESP: begin
                DataValid_OUT = 1'b1;
                state_d       = IDLE;
            end
            RMW_RD: begin
                sram_en = 1'b1;
                state_d = RMW_MRG;
            end
            RMW_MRG: state_d = WR;
            WR: begin
                sram_en = 1'b1;
                sram_we = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt     <= '0;
            op_addr      <= '0;
            op_data      <= '0;
            op_size      <= '0;
            op_load      <= 1'b0;
            wr_word      <= '0;
            ReadData_OUT <= '0;
            flush_pend   <= 1'b0;
            Overflow_OUT <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
            if (take_store) begin
                op_addr <= head.addr;
                op_data <= head.data;
                op_size <= head.size;
                op_load <= 1'b0;
                wr_word <= head.data;
            end
            if (take_load) begin
                op_addr <= Address_IN[ADDR_W+1:0];
                op_load <= 1'b1;
            end
            if (state == RDCAP)   ReadData_OUT <= sram_rdata;
            if (state == RMW_MRG) wr_word      <= merged;
            flush_pend   <= MemFlush_IN || (flush_pend && !flush_fire);
            Overflow_OUT <= Overflow_OUT || (MemWrite_IN && full);
        end
    end

    assign Busy_OUT      = full;
    assign FlushDone_OUT = flush_fire;
    assign sram_addr     = op_addr[ADDR_W+1:2];
    assign sram_wdata    = wr_word;

endmodule
